// File: rtl/framing_pkg.sv
// rtl/framing_pkg.sv - shared framing constants, state encoding and escape rule (honours FRAMER_ESCAPE_START_EN)
package framing_pkg;

    // Default delimiter values, shared with the receive-side deframer.
    localparam logic [7:0] ESCAPE_BYTE_DEF = 8'h7F;
    localparam logic [7:0] START_BYTE_DEF  = 8'h7D;
    localparam logic [7:0] STOP_BYTE_DEF   = 8'h7E;

    // When set, payload bytes equal to START are escaped too, so a receiver
    // can resynchronise on any raw START it sees on the link.
`ifdef FRAMER_ESCAPE_START_EN
    localparam logic ESCAPE_START = 1'b1;
`else
    localparam logic ESCAPE_START = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ESC  = 2'd2,
        STOP = 2'd3
    } state_t;

    // A payload byte must be prefixed with ESCAPE when it collides with a
    // byte the receiver treats as framing.
    function automatic logic needs_escape(
        input logic [7:0] b,
        input logic [7:0] esc_b,
        input logic [7:0] start_b,
        input logic [7:0] stop_b
    );
        return (b == esc_b) || (b == stop_b) || (ESCAPE_START && (b == start_b));
    endfunction

endpackage

// File: rtl/axi4s_framer.sv
// rtl/axi4s_framer.sv - AXI4-Stream byte framer: START, escaped payload, STOP (option: FRAMER_ESCAPE_START_EN)
module axi4s_framer
    import framing_pkg::*;
#(
    parameter logic [7:0] ESCAPE_BYTE = ESCAPE_BYTE_DEF,
    parameter logic [7:0] START_BYTE  = START_BYTE_DEF,
    parameter logic [7:0] STOP_BYTE   = STOP_BYTE_DEF
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       target_tvalid,
    output logic       target_tready,
    input  logic [7:0] target_tdata,
    input  logic       target_tlast,
    output logic       initiator_tvalid,
    input  logic       initiator_tready,
    output logic [7:0] initiator_tdata,
    output logic       initiator_tlast
);

    state_t     state_q, state_d;
    logic       tvalid_q, tvalid_d;
    logic [7:0] tdata_q, tdata_d;
    logic       tlast_q, tlast_d;
    logic       out_free;
    logic       needs_esc;

    assign out_free  = !tvalid_q || initiator_tready;
    assign needs_esc = needs_escape(target_tdata, ESCAPE_BYTE, START_BYTE, STOP_BYTE);

    // ESC consumes the byte that DATA refused; the input is held stable by the
    // upstream handshake, so no local copy of it is kept.
    assign target_tready = out_free && (((state_q == DATA) && !needs_esc) || (state_q == ESC));

    assign initiator_tvalid = tvalid_q;
    assign initiator_tdata  = tdata_q;
    assign initiator_tlast  = tlast_q;

    // Next-state and output-slot load; everything holds while the slot is occupied and stalled.
    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        if (out_free) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (target_tvalid) begin
                        tvalid_d = 1'b1;
                        tdata_d  = START_BYTE;
                        state_d  = DATA;
                    end
                end
                DATA: begin
                    if (target_tvalid) begin
                        tvalid_d = 1'b1;
                        if (needs_esc) begin
                            tdata_d = ESCAPE_BYTE;
                            state_d = ESC;
                        end else begin
                            tdata_d = target_tdata;
                            state_d = target_tlast ? STOP : DATA;
                        end
                    end
                end
                ESC: begin
                    if (target_tvalid) begin
                        tvalid_d = 1'b1;
                        tdata_d  = target_tdata;
                        state_d  = target_tlast ? STOP : DATA;
                    end
                end
                STOP: begin
                    tvalid_d = 1'b1;
                    tdata_d  = STOP_BYTE;
                    tlast_d  = 1'b1;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // FSM and output slot registers; reset drops any partial frame.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

endmodule

// File: tb/tb_axi4s_framer.sv
// tb/tb_axi4s_framer.sv - directed and randomised-backpressure bench for axi4s_framer
module tb_axi4s_framer;

    logic       aclk = 1'b0;
    logic       areset;
    logic       target_tvalid;
    logic       target_tready;
    logic [7:0] target_tdata;
    logic       target_tlast;
    logic       initiator_tvalid;
    logic       initiator_tready;
    logic [7:0] initiator_tdata;
    logic       initiator_tlast;

    axi4s_framer dut (
        .aclk             (aclk),
        .areset           (areset),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .target_tlast     (target_tlast),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tdata  (initiator_tdata),
        .initiator_tlast  (initiator_tlast)
    );

    always #5 aclk = ~aclk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         trdy_lo = 0;
    int         trdy_hi = 0;
    logic [8:0] src_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] out_q[$];
    int         out_cyc[$];
    logic       rand_ready = 1'b0;
    logic       stalled = 1'b0;
    logic [8:0] stall_val = 9'h000;
    logic       in_frame = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic tb_esc(input logic [7:0] b);
`ifdef FRAMER_ESCAPE_START_EN
        return (b == 8'h7F) || (b == 8'h7E) || (b == 8'h7D);
`else
        return (b == 8'h7F) || (b == 8'h7E);
`endif
    endfunction

    // Reference framing for the random run: appends one payload byte and its expected output beats.
    task automatic add_byte(input logic [7:0] b, input logic last);
        src_q.push_back({last, b});
        if (!in_frame) exp_q.push_back({1'b0, 8'h7D});
        in_frame = !last;
        if (tb_esc(b)) exp_q.push_back({1'b0, 8'h7F});
        exp_q.push_back({1'b0, b});
        if (last) exp_q.push_back({1'b1, 8'h7E});
    endtask

    // One clock: drive at negedge, then record what the next rising edge will transfer.
    task automatic step();
        @(negedge aclk);
        cyc++;
        initiator_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (src_q.size() > 0) begin
            target_tvalid = 1'b1;
            {target_tlast, target_tdata} = src_q[0];
        end else begin
            target_tvalid = 1'b0;
            target_tlast  = 1'b0;
            target_tdata  = 8'h00;
        end
        #1;
        if (stalled) begin
            check_eq("stall_tvalid", initiator_tvalid, 1);
            check_eq("stall_beat", {initiator_tlast, initiator_tdata}, stall_val);
        end
        stalled   = initiator_tvalid && !initiator_tready;
        stall_val = {initiator_tlast, initiator_tdata};
        if (initiator_tvalid && initiator_tready) begin
            out_q.push_back({initiator_tlast, initiator_tdata});
            out_cyc.push_back(cyc);
        end
        if (target_tvalid) begin
            if (target_tready) begin
                void'(src_q.pop_front());
                trdy_hi++;
            end else begin
                trdy_lo++;
            end
        end
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while ((src_q.size() > 0 || out_q.size() < exp_q.size() || initiator_tvalid) && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_timeout"}, n < budget, 1);
    endtask

    task automatic compare_out(input string tag, input int span_exp);
        int span;
        check_eq({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [8:0] g;
            g = (i < out_q.size()) ? out_q[i] : 9'bx;
            check_eq($sformatf("%s_beat%0d", tag, i), g, exp_q[i]);
        end
        if (span_exp >= 0) begin
            span = (out_q.size() > 0) ? out_cyc[out_q.size() - 1] - out_cyc[0] : -1;
            check_eq({tag, "_span"}, span, span_exp);
        end
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        areset           = 1'b1;
        target_tvalid    = 1'b0;
        target_tdata     = 8'h00;
        target_tlast     = 1'b0;
        initiator_tready = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        check_eq("rst_tvalid", initiator_tvalid, 0);
        check_eq("rst_tdata", initiator_tdata, 8'h00);
        check_eq("rst_tlast", initiator_tlast, 0);
        check_eq("rst_tready", target_tready, 0);
        areset = 1'b0;

        // Plain packet: 7D 01 02 03 7E on consecutive cycles.
        src_q = '{9'h001, 9'h002, 9'h103};
        exp_q = '{9'h07D, 9'h001, 9'h002, 9'h003, 9'h17E};
        run_until_done("t1", 50);
        compare_out("t1", 4);

        // Escaped bytes, tlast on the escaped byte; tready low in IDLE and both ESCAPE-insert cycles.
        trdy_lo = 0;
        trdy_hi = 0;
        src_q = '{9'h07F, 9'h17E};
        exp_q = '{9'h07D, 9'h07F, 9'h07F, 9'h07F, 9'h07E, 9'h17E};
        run_until_done("t2", 50);
        compare_out("t2", 5);
        check_eq("t2_tready_low", trdy_lo, 3);
        check_eq("t2_tready_high", trdy_hi, 2);

        // START value in payload.
        src_q = '{9'h07D, 9'h110};
`ifdef FRAMER_ESCAPE_START_EN
        exp_q = '{9'h07D, 9'h07F, 9'h07D, 9'h010, 9'h17E};
        run_until_done("t3", 50);
        compare_out("t3", 4);
`else
        exp_q = '{9'h07D, 9'h07D, 9'h010, 9'h17E};
        run_until_done("t3", 50);
        compare_out("t3", 3);
`endif

        // Back-to-back single-byte packets, no idle cycle between frames.
        src_q = '{9'h1AA, 9'h1BB};
        exp_q = '{9'h07D, 9'h0AA, 9'h17E, 9'h07D, 9'h0BB, 9'h17E};
        run_until_done("t5", 50);
        compare_out("t5", 5);

        // Reset mid-frame after 7D,01 of a 4-byte packet.
        src_q = '{9'h001, 9'h002, 9'h003, 9'h104};
        begin
            int n = 0;
            while (out_q.size() < 2 && n < 50) begin
                step();
                n++;
            end
        end
        exp_q = '{9'h07D, 9'h001};
        compare_out("t6_pre", -1);
        @(negedge aclk);
        areset        = 1'b1;
        target_tvalid = 1'b0;
        @(negedge aclk);
        #1;
        check_eq("t6_tvalid", initiator_tvalid, 0);
        check_eq("t6_tlast", initiator_tlast, 0);
        areset        = 1'b0;
        target_tvalid = 1'b1;
        target_tdata  = 8'h05;
        target_tlast  = 1'b1;
        #1;
        check_eq("t6_idle_tready", target_tready, 0);
        src_q.delete();
        stalled = 1'b0;
        src_q = '{9'h105};
        exp_q = '{9'h07D, 9'h005, 9'h17E};
        run_until_done("t6_post", 50);
        compare_out("t6_post", 2);

        // 100 random packets under 50% downstream backpressure.
        rand_ready = 1'b1;
        in_frame   = 1'b0;
        for (int p = 0; p < 100; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                logic [7:0] b;
                case ($urandom_range(0, 5))
                    0: b = 8'h7D;
                    1: b = 8'h7E;
                    2: b = 8'h7F;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                add_byte(b, k == len - 1);
            end
        end
        run_until_done("rnd", 20000);
        compare_out("rnd", -1);
        rand_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4s_framer.md
# axi4s_framer

- Transmit-side byte framer for AXI4-Stream.
- Takes packets delimited by tlast and emits a flat byte stream:
  - START_BYTE
  - payload, with reserved values escape-prefixed
  - STOP_BYTE, flagged with initiator_tlast
- Sits directly upstream of the link that feeds the receive-side deframer.

## Interface
Parameters:
- ESCAPE_BYTE, 8'h7F, escape prefix byte
- START_BYTE, 8'h7D, frame-open byte
- STOP_BYTE, 8'h7E, frame-close byte

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  reset; synchronous, active-high
- target_tvalid  in  1  payload byte valid
- target_tready  out  1  payload byte accepted
- target_tdata  in  8  payload byte
- target_tlast  in  1  last payload byte of packet
- initiator_tvalid  out  1  framed byte valid
- initiator_tready  in  1  downstream ready
- initiator_tdata  out  8  framed byte
- initiator_tlast  out  1  high only on the STOP_BYTE beat

## Operation
- Output is a single registered slot: initiator_tvalid, initiator_tdata, initiator_tlast are flops.
- out_free = !initiator_tvalid || initiator_tready.
- The slot loads only when out_free; when not out_free, all outputs and the state hold.
- needs_esc = (target_tdata == ESCAPE_BYTE) || (target_tdata == STOP_BYTE).

FSM states, all transitions gated by out_free:
- IDLE: on target_tvalid, load START_BYTE (tlast 0) -> DATA. No input consumed.
- DATA, target_tvalid && !needs_esc: load target_tdata and consume it.
  - If target_tlast -> STOP, else stay in DATA.
- DATA, target_tvalid && needs_esc: load ESCAPE_BYTE, consume nothing -> ESC.
- ESC: load the held target_tdata unescaped and consume it.
  - If target_tlast -> STOP, else -> DATA.
- STOP: load STOP_BYTE with tlast 1 -> IDLE.

Handshake and data rules:
- target_tready = out_free && ((state==DATA && !needs_esc) || state==ESC). It is combinational from state, target_tdata and initiator_tready.
- target_tdata and target_tlast must stay stable while target_tvalid is high and unaccepted (AXI rule). The ESC state relies on this; no internal data copy is kept.
- START_BYTE in the payload is sent unescaped, unless the macro below is enabled.
- Output tvalid deasserts only when the slot is drained and nothing is loaded that cycle.

## Timing
- Reset values: initiator_tvalid 0, initiator_tdata 8'h00, initiator_tlast 0, state IDLE.
- Reset mid-frame: the partial frame is dropped with no STOP emitted. Output is idle the cycle after reset.
- Latency: target_tvalid rising in IDLE gives START on initiator one cycle later. The first payload byte follows on the next cycle, assuming initiator_tready is high.
- Throughput with tready constantly high: one output byte per cycle.
  - A frame of N payload bytes with E escaped bytes takes N+E+2 output cycles.
- Back-to-back packets: IDLE costs no extra cycle beyond emitting START. There is no gap between STOP of one frame and START of the next.
- Backpressure: initiator_tready low freezes everything. Data, state and target_tready (which is low) all hold.
- Single-byte packet with tlast: START, byte, STOP.
- If the escaped byte also carries tlast: ESCAPE, byte, STOP.

## Configuration
- FRAMER_ESCAPE_START_EN defined: needs_esc also matches START_BYTE, so payload 8'h7D goes out as ESCAPE_BYTE, 8'h7D.
  - This lets receivers resynchronise on any unescaped START.
- Undefined: START_BYTE is passed raw, as described above.

## Structure
- Shared package framing_pkg holds:
  - default ESCAPE/START/STOP byte constants, shared with the deframer
  - state enum typedef {IDLE, DATA, ESC, STOP}
  - function needs_escape(byte), honouring FRAMER_ESCAPE_START_EN
- No sub-module. The output slot is inline; the FSM and the slot live in one always_ff block.

## Test plan
- Packet 8'h01,8'h02,8'h03 (tlast on 03), tready=1 -> output 7D,01,02,03,7E; tlast only on 7E; 5 consecutive valid cycles.
- Packet 8'h7F,8'h7E (tlast on 7E) -> 7D,7F,7F,7F,7E,7E; target_tready low during each inserted ESCAPE cycle.
- Packet 8'h7D,8'h10 -> without macro 7D,7D,10,7E; with FRAMER_ESCAPE_START_EN 7D,7F,7D,10,7E.
- Random initiator_tready toggling (50%) over 100 random packets -> output matches reference framing byte-for-byte; no tvalid drop or data change while stalled.
- Two back-to-back single-byte packets 8'hAA, 8'hBB -> 7D,AA,7E,7D,BB,7E with no idle cycle.
- areset asserted after 7D,01 of a 4-byte packet -> next cycle tvalid 0, state IDLE; the next packet starts with a fresh 7D.
